// File: rtl/mod_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_updown_counter_pkg
// Shared definitions for the loadable up/down modulo counter:
//   - end-of-range mode encodings (wrap / saturate / one-shot)
//   - counter state encoding (COUNT while running, HOLD once a one-shot ends)
// ---------------------------------------------------------------------------
package mod_updown_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_updown_counter_cnt_next_logic.sv
// ---------------------------------------------------------------------------
// cnt_next_logic
// Combinational step computation for one enabled counting edge.
// Ports:
//   count_i      current count
//   up_i         1 = increment, 0 = decrement
//   max_val_i    modulo limit (range 0..max_val_i)
//   mode_i       end-of-range mode (2'b11 behaves as wrap)
//   next_count_o count after the enabled step
//   wrap_o       the step wraps around the range
//   enter_hold_o the step finishes a one-shot run
// ---------------------------------------------------------------------------
module cnt_next_logic
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             wrap_o,
  output logic             enter_hold_o
);

  logic [WIDTH-1:0] term;

  assign term = up_i ? max_val_i : '0;

  // The out-of-range and terminal checks come before the +/-1 so the
  // increment never passes max_val and the decrement never passes zero.
  always_comb begin
    next_count_o = count_i;
    wrap_o       = 1'b0;
    enter_hold_o = 1'b0;
    if (count_i > max_val_i) begin
      // max_val was lowered underneath a running count: snap to the limit.
      next_count_o = max_val_i;
    end else if (count_i != term) begin
      next_count_o = up_i ? (count_i + 1'b1) : (count_i - 1'b1);
    end else begin
      case (mode_i)
        MODE_SAT: begin
          next_count_o = count_i;
        end
        MODE_ONESHOT: begin
          next_count_o = count_i;
          enter_hold_o = 1'b1;
        end
        default: begin
          // Wrap (and the reserved encoding): jump to the opposite end.
          next_count_o = up_i ? '0 : max_val_i;
          wrap_o       = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_updown_counter
// Loadable up/down modulo counter with wrap / saturate / one-shot end modes
// and a combinational terminal-count output for cascading stages.
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   clear     synchronous clear (highest priority)
//   enable    count enable / cascade input from a lower stage's tc_o
//   up        direction, 1 = increment
//   load      synchronous load of min(load_val, max_val)
//   load_val  load value
//   max_val   modulo limit, range 0..max_val
//   mode      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   count     current count (register)
//   tc_o      combinational terminal count for cascading
//   wrap_o    registered one-cycle pulse per wrap
//   done      registered, high while a finished one-shot is holding
// ---------------------------------------------------------------------------
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             done_q;

  logic [WIDTH-1:0] count_d;
  logic             step_wrap;
  logic             step_hold;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] term;

  cnt_next_logic #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i      (count_q),
    .up_i         (up),
    .max_val_i    (max_val),
    .mode_i       (mode),
    .next_count_o (count_d),
    .wrap_o       (step_wrap),
    .enter_hold_o (step_hold)
  );

  assign load_clamped = (load_val > max_val) ? max_val : load_val;
  assign term         = up ? max_val : '0;

  // Only meaningful while counting; a holding one-shot never cascades.
  assign tc_o = enable & (count_q == term) & (state_q == ST_COUNT);

  // Count register, wrap pulse and COUNT/HOLD machine. done mirrors HOLD
  // but is kept as its own register so the output is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_COUNT;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        count_q <= '0;
        state_q <= ST_COUNT;
        done_q  <= 1'b0;
      end else if (load) begin
        count_q <= load_clamped;
        state_q <= ST_COUNT;
        done_q  <= 1'b0;
      end else if (enable && (state_q == ST_COUNT)) begin
        count_q <= count_d;
        wrap_q  <= step_wrap;
        if (step_hold) begin
          state_q <= ST_HOLD;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign count  = count_q;
  assign wrap_o = wrap_q;
  assign done   = done_q;

endmodule
